// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MIPS-style multiply/divide unit with HI/LO registers
module mul_div_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic          res_valid_q, res_valid_d;
    logic [31:0]   hi_d, lo_d;

    logic          accept;
    logic [63:0]   prod_s, prod_u;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

    assign busy   = (cnt_q != '0);
    assign accept = start && !req && !busy;

    // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'b0, a} * {32'b0, b};
        a_neg  = (op == OP_DIV) && a[31];
        b_neg  = (op == OP_DIV) && b[31];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        b_div  = (b_mag == '0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_div;
        r_mag  = a_mag % b_div;
        quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;
        res_valid_d = res_valid_q;
        hi_d        = hi;
        lo_d        = lo;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            {res_hi_d, res_lo_d} = (op == OP_MULT) ? prod_s : prod_u;
                            res_valid_d = 1'b1;
                            cnt_d       = CW'(MUL_LAT);
                            state_d     = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            res_hi_d    = rem;
                            res_lo_d    = quo;
                            res_valid_d = (b != '0);
                            cnt_d       = CW'(DIV_LAT);
                            state_d     = BUSY;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (res_valid_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
            res_valid_q <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
            res_valid_q <= res_valid_d;
            hi          <= hi_d;
            lo          <= lo_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized and directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        req = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mul_div_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .req(req), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int op_lat(input logic [2:0] o);
        if (o <= 3'd1) return MUL_LAT;
        if (o <= 3'd3) return DIV_LAT;
        return 0;
    endfunction

    // Architectural result of an accepted op, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl);
        longint sx, sy, p;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        rh = m_hi;
        rl = m_lo;
        case (o)
            3'd0: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
            3'd2: if (y != 0) begin p = sx / sy; rl = p[31:0]; p = sx % sy; rh = p[31:0]; end
            3'd3: if (y != 0) begin up = ux / uy; rl = up[31:0]; up = ux % uy; rh = up[31:0]; end
            3'd4: rh = x;
            3'd5: rl = x;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit rq, input bit inject);
        logic [31:0] rh, rl;
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; req = rq;
        @(posedge clk); #1;
        start = 1'b0; req = 1'b0;
        lat = rq ? 0 : op_lat(o);
        if (rq) begin rh = m_hi; rl = m_lo; end
        else model(o, x, y, rh, rl);
        for (int i = 1; i <= lat; i++) begin
            check_eq("busy_during", {31'b0, busy}, 32'd1);
            check_eq("hi_hold", hi, m_hi);
            check_eq("lo_hold", lo, m_lo);
            if (inject && i == 3) begin
                start = 1'b1; op = 3'b011; a = $urandom; b = 32'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        m_hi = rh;
        m_lo = rl;
        check_eq("busy_done", {31'b0, busy}, 32'd0);
        check_eq("hi_done", hi, m_hi);
        check_eq("lo_done", lo, m_lo);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        #1 reset = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        check_eq("mult_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", lo, 32'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check_eq("multu_hi", hi, 32'd1);
        check_eq("multu_lo", lo, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check_eq("div_hi", hi, 32'hFFFF_FFFF);
        check_eq("div_lo", lo, 32'hFFFF_FFFD);
        run_op(3'd3, 32'd1234, 32'd0, 1'b0, 1'b0);
        check_eq("divz_lo", lo, 32'hFFFF_FFFD);
        run_op(3'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
        check_eq("mtlo", lo, 32'h1234);
        run_op(3'd5, 32'h5678, 32'd0, 1'b1, 1'b0);
        check_eq("mtlo_req", lo, 32'h1234);
        run_op(3'd0, 32'd7, 32'd9, 1'b1, 1'b0);
        run_op(3'd6, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);
        run_op(3'd7, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_eq("ovf_lo", lo, 32'h8000_0000);
        check_eq("ovf_hi", hi, 32'd0);
        run_op(3'd0, 32'd1000, 32'hFFFF_FFFD, 1'b0, 1'b1);
        check_eq("inject_lo", lo, 32'hFFFF_F448);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op(3'($urandom_range(0, 7)), ra, rb, ($urandom_range(0, 4) == 0), 1'b0);
        end

        run_op(3'd4, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_busy", {31'b0, busy}, 32'd0);
        check_eq("arst_hi", hi, 32'd0);
        check_eq("arst_lo", lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (DIV_LAT) @(posedge clk);
        #1;
        check_eq("post_rst_busy", {31'b0, busy}, 32'd0);
        check_eq("post_rst_hi", hi, 32'd0);
        check_eq("post_rst_lo", lo, 32'd0);
        #2 reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        run_op(3'd5, 32'hA5A5_0F0F, 32'd0, 1'b0, 1'b0);
        check_eq("first_edge_lo", lo, 32'hA5A5_0F0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
